// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side controller for the byte FIFO. Pops words in
// bursts (full BURST-word bursts, or a short flush after TIMEOUT idle cycles
// with a partial fill) and presents them on a registered valid/ready stream
// with m_last marking the final word of each burst.
module fifo_burst_reader #(
    parameter int MAX_DATA = 16,
    parameter int BURST    = 4,
    parameter int TIMEOUT  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     fifo_rdata,
    input  logic [$clog2(MAX_DATA+1)-1:0]  fifo_count,
    input  logic                           fifo_empty,
    output logic                           fifo_ren,
    output logic                           fifo_lock,
    output logic [7:0]                     m_data,
    output logic                           m_valid,
    output logic                           m_last,
    input  logic                           m_ready,
    output logic                           busy
);

    localparam int CNT_W = $clog2(MAX_DATA + 1);
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    localparam logic [CNT_W-1:0] BURST_N  = CNT_W'(BURST);
    localparam logic [CNT_W-1:0] ONE_N    = CNT_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] remaining_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [7:0]       m_data_q;
    logic             m_valid_q;
    logic             m_last_q;
    logic             pop;

    // Pop when a burst is open, the FIFO has data and the output slot is free
    // or being freed this cycle; held low during reset so an aborted burst
    // leaves its unpopped words in the FIFO.
    assign pop = (state_q == XFER) && (remaining_q != '0) && !fifo_empty
                 && (!m_valid_q || m_ready) && !rst;

    assign fifo_ren  = pop;
    assign fifo_lock = (state_q == IDLE);
    assign busy      = (state_q == XFER);
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;

    // Burst FSM: start full bursts on occupancy, short bursts on timeout,
    // count down popped words and return to IDLE after the last one.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every register in the
        // block sees the pre-edge values of the others.
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_count >= BURST_N) begin
                        state_q     <= XFER;
                        remaining_q <= BURST_N;
                        tmo_cnt_q   <= '0;
                    end else if (fifo_count != '0) begin
                        if (tmo_cnt_q == TMO_LAST) begin
                            state_q     <= XFER;
                            remaining_q <= fifo_count;
                            tmo_cnt_q   <= '0;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
                    end else begin
                        tmo_cnt_q <= '0;
                    end
                end
                XFER: begin
                    if (pop) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == ONE_N) begin
                            state_q <= IDLE;
                        end
                    end else if (remaining_q == '0) begin
                        // Defensive: an empty burst never holds the block.
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output register: load on a pop, clear on acceptance, otherwise hold so
    // a stalled word is never altered or dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (pop) begin
            m_data_q  <= fifo_rdata;
            m_valid_q <= 1'b1;
            m_last_q  <= (remaining_q == ONE_N);
        end else if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: drives it from a behavioural 16-entry FIFO
// and checks the delivered stream against bursts derived from write groups.
module tb_fifo_burst_reader;

    localparam int MAX_DATA = 16;
    localparam int BURST    = 4;
    localparam int TIMEOUT  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] fifo_rdata;
    logic [4:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_ren;
    logic       fifo_lock;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       busy;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .MAX_DATA (MAX_DATA),
        .BURST    (BURST),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_rdata (fifo_rdata),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .fifo_lock  (fifo_lock),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy)
    );

    // Behavioural FIFO with a combinational read port forced to 0 when locked.
    logic [7:0] mem [MAX_DATA];
    logic [3:0] rp  = '0;
    logic [3:0] wp  = '0;
    logic [4:0] cnt = '0;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       do_wr;
    logic       do_rd;

    assign do_wr      = wr_en && (cnt != 5'd16);
    assign do_rd      = fifo_ren && (cnt != 5'd0);
    assign fifo_count = cnt;
    assign fifo_empty = (cnt == 5'd0);
    assign fifo_rdata = fifo_lock ? 8'h00 : mem[rp];

    always @(posedge clk) begin
        if (do_wr) begin
            mem[wp] <= wr_data;
            wp      <= wp + 4'd1;
        end
        if (do_rd) rp <= rp + 4'd1;
        cnt <= cnt + {4'd0, do_wr} - {4'd0, do_rd};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_errors++;
            $error("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Reference model: a group of consecutively written words leaves as
    // bursts of BURST words in write order, the final chunk possibly short;
    // m_last marks each chunk end.
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] grp[$];
    bit         rand_rdy = 1'b0;

    task automatic expect_beat(input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic fill_group(input int k);
        grp.delete();
        for (int i = 0; i < k; i++) grp.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic model_group();
        for (int i = 0; i < grp.size(); i++)
            expect_beat(grp[i], ((i % BURST) == BURST - 1) || (i == grp.size() - 1));
    endtask

    task automatic push_word(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic push_group();
        for (int i = 0; i < grp.size(); i++) push_word(grp[i]);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy || m_valid || fifo_count != 5'd0) && n < 400) begin
            if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_in_time"}, 32'(n < 400), 1);
        check({tag, "_words_left"}, 32'(exp_q.size()), 0);
    endtask

    // Stream monitor, sampled just before each rising edge: every accepted
    // word must be the next expected one, and a stalled word must not change.
    logic       hold_pending = 1'b0;
    logic [7:0] held_data;
    logic       held_last;
    beat_t      got_b;

    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 32'(m_valid), 1);
                check("hold_data", 32'(m_data), 32'(held_data));
                check("hold_last", 32'(m_last), 32'(held_last));
            end
            if (m_valid && m_ready) begin
                check("word_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    got_b = exp_q.pop_front();
                    check("word_data", 32'(m_data), 32'(got_b.data));
                    check("word_last", 32'(m_last), 32'(got_b.last));
                end
            end
            hold_pending = m_valid && !m_ready;
            held_data    = m_data;
            held_last    = m_last;
        end
    end

    int t_wr;
    int n;
    int nb;

    initial begin
        rst     = 1'b1;
        m_ready = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fifo_ren", 32'(fifo_ren), 0);
        check("rst_fifo_lock", 32'(fifo_lock), 1);
        rst = 1'b0;

        // Full burst: latency, one word per cycle, XFER for BURST cycles.
        m_ready = 1'b1;
        fill_group(BURST);
        model_group();
        push_group();
        t_wr = cyc;
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        check("full_start_latency", cyc - t_wr, 1);
        nb = 1;
        @(negedge clk);
        for (int i = 0; i < BURST; i++) begin
            nb += int'(busy);
            check("full_valid", 32'(m_valid), 1);
            check("full_data", 32'(m_data), 32'(grp[i]));
            check("full_last", 32'(m_last), 32'(i == BURST - 1));
            @(negedge clk);
        end
        check("full_xfer_cycles", nb, BURST);
        check("full_count_end", 32'(fifo_count), 0);
        drain("full");

        // Backpressure: stall three cycles while the second word is valid.
        fill_group(BURST);
        model_group();
        push_group();
        n = 0;
        while (!m_valid && n < 20) begin @(negedge clk); n++; end
        check("bp_first_word", 32'(m_data), 32'(grp[0]));
        @(negedge clk);
        check("bp_second_word", 32'(m_data), 32'(grp[1]));
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ren_low", 32'(fifo_ren), 0);
            check("bp_hold_data", 32'(m_data), 32'(grp[1]));
            check("bp_hold_valid", 32'(m_valid), 1);
            @(negedge clk);
        end
        m_ready = 1'b1;
        drain("bp");

        // Timeout flush of a two-word partial fill.
        fill_group(2);
        model_group();
        push_word(grp[0]);
        t_wr = cyc;
        push_word(grp[1]);
        n = 0;
        while (!busy && n < 40) begin @(negedge clk); n++; end
        check("tmo_flush_delay", cyc - t_wr, TIMEOUT);
        drain("tmo");

        // Fourth word lands on the last edge before the flush would fire.
        fill_group(BURST);
        model_group();
        for (int i = 0; i < 3; i++) push_word(grp[i]);
        repeat (TIMEOUT - 4) @(negedge clk);
        check("fill_no_early_flush", 32'(busy), 0);
        push_word(grp[3]);
        drain("fill");

        // Full FIFO: fill while held in reset, then four back-to-back bursts.
        rst = 1'b1;
        @(negedge clk);
        fill_group(MAX_DATA);
        model_group();
        push_group();
        check("ff_count_full", 32'(fifo_count), MAX_DATA);
        check("ff_ren_in_rst", 32'(fifo_ren), 0);
        rst     = 1'b0;
        m_ready = 1'b1;
        drain("fifo16");

        // Reset while the second word of a burst sits in the output register.
        fill_group(BURST);
        expect_beat(grp[0], 1'b0);
        push_group();
        n = 0;
        while (!m_valid && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        check("rmb_second_word", 32'(m_data), 32'(grp[1]));
        rst     = 1'b1;
        m_ready = 1'b0;
        #1;
        check("rmb_ren_in_rst", 32'(fifo_ren), 0);
        @(negedge clk);
        check("rmb_m_valid", 32'(m_valid), 0);
        check("rmb_m_last", 32'(m_last), 0);
        check("rmb_m_data", 32'(m_data), 0);
        check("rmb_busy", 32'(busy), 0);
        check("rmb_fifo_lock", 32'(fifo_lock), 1);
        check("rmb_fifo_count", 32'(fifo_count), 2);
        expect_beat(grp[2], 1'b0);
        expect_beat(grp[3], 1'b1);
        rst     = 1'b0;
        m_ready = 1'b1;
        drain("rmb");

        // Random groups with random consumer stalls.
        rand_rdy = 1'b1;
        for (int g = 0; g < 12; g++) begin
            fill_group(int'($urandom_range(1, 2 * BURST)));
            model_group();
            push_group();
            drain("rand");
        end
        rand_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
